// File: rtl/stats_mmio_peripheral.sv
// Memory-mapped running min/max/sum/count with a multicycle signed average.
// Define STATS_IRQ_EN to add a registered irq output (done & irq_enable).
module stats_mmio_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit
`ifdef STATS_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } state_t;

  localparam logic [2:0] R_DATA = 3'd0;
  localparam logic [2:0] R_CTRL = 3'd1;
  localparam logic [2:0] R_STAT = 3'd2;
  localparam logic [2:0] R_MIN  = 3'd3;
  localparam logic [2:0] R_MAX  = 3'd4;
  localparam logic [2:0] R_SUM  = 3'd5;
  localparam logic [2:0] R_CNT  = 3'd6;
  localparam logic [2:0] R_AVG  = 3'd7;

  state_t      state, state_n;
  logic [31:0] mn, mn_n;
  logic [31:0] mx, mx_n;
  logic [31:0] sum, sum_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] avg, avg_n;
  logic        done, done_n;
  logic        err, err_n;
  logic        ovf, ovf_n;
  logic        ien, ien_n;
  logic [31:0] dvs, dvs_n;
  logic [31:0] quo, quo_n;
  logic [32:0] rem, rem_n;
  logic        neg, neg_n;
  logic [4:0]  step, step_n;

  logic [2:0]  off;
  logic        push;
  logic        cwr;
  logic        clr;
  logic        start;
  logic [31:0] sum_add;
  logic [32:0] shl;
  logic [32:0] diff;
  logic [31:0] avg_fix;
  logic        unused;

  assign unused  = ^Addr[1:0];
  assign off     = Addr[4:2];
  assign hit     = (Addr[31:5] == BASE_ADDR[31:5]);
  assign push    = MemWrite & hit & (off == R_DATA);
  assign cwr     = MemWrite & hit & (off == R_CTRL);
  assign clr     = cwr & WriteData[0];
  assign start   = cwr & WriteData[1] & ~WriteData[0]
                 & (state == IDLE);
  assign sum_add = sum + WriteData;
  assign shl     = {rem[31:0], quo[31]};
  assign diff    = shl - {1'b0, dvs};
  assign avg_fix = neg ? (32'd0 - quo) : quo;

  always_comb begin
    state_n = state;
    mn_n    = mn;
    mx_n    = mx;
    sum_n   = sum;
    cnt_n   = cnt;
    avg_n   = avg;
    done_n  = done;
    err_n   = err;
    ovf_n   = ovf;
    ien_n   = ien;
    dvs_n   = dvs;
    quo_n   = quo;
    rem_n   = rem;
    neg_n   = neg;
    step_n  = step;

    // Restoring divider: quo shifts dividend bits out, quotient bits in.
    unique case (state)
      IDLE: begin
      end
      DIV: begin
        if (dvs == 32'd0) begin
          avg_n   = 32'd0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          if (!diff[32]) begin
            rem_n = diff;
            quo_n = {quo[30:0], 1'b1};
          end else begin
            rem_n = shl;
            quo_n = {quo[30:0], 1'b0};
          end
          step_n = step + 5'd1;
          if (step == 5'd31) state_n = FIX;
        end
      end
      FIX: begin
        avg_n   = avg_fix;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (push) begin
      mn_n  = ($signed(WriteData) < $signed(mn)) ? WriteData : mn;
      mx_n  = ($signed(WriteData) > $signed(mx)) ? WriteData : mx;
      sum_n = sum_add;
      ovf_n = ovf | ((sum[31] == WriteData[31]) &
                     (sum_add[31] != sum[31]));
      cnt_n = (&cnt) ? cnt : cnt + 32'd1;
    end

    if (cwr) ien_n = WriteData[2];

    if (clr) begin
      state_n = IDLE;
      mn_n    = 32'h7FFF_FFFF;
      mx_n    = 32'h8000_0000;
      sum_n   = 32'd0;
      cnt_n   = 32'd0;
      avg_n   = 32'd0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      ovf_n   = 1'b0;
      step_n  = 5'd0;
    end else if (start) begin
      state_n = DIV;
      dvs_n   = cnt;
      quo_n   = sum[31] ? (32'd0 - sum) : sum;
      rem_n   = 33'd0;
      neg_n   = sum[31];
      step_n  = 5'd0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mn    <= 32'h7FFF_FFFF;
      mx    <= 32'h8000_0000;
      sum   <= 32'd0;
      cnt   <= 32'd0;
      avg   <= 32'd0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
      ien   <= 1'b0;
      dvs   <= 32'd0;
      quo   <= 32'd0;
      rem   <= 33'd0;
      neg   <= 1'b0;
      step  <= 5'd0;
    end else begin
      state <= state_n;
      mn    <= mn_n;
      mx    <= mx_n;
      sum   <= sum_n;
      cnt   <= cnt_n;
      avg   <= avg_n;
      done  <= done_n;
      err   <= err_n;
      ovf   <= ovf_n;
      ien   <= ien_n;
      dvs   <= dvs_n;
      quo   <= quo_n;
      rem   <= rem_n;
      neg   <= neg_n;
      step  <= step_n;
    end
  end

`ifdef STATS_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= done_n & ien_n;
  end
`endif

  always_comb begin
    ReadData = 32'd0;
    if (hit) begin
      case (off)
        R_DATA:  ReadData = 32'd0;
        R_CTRL:  ReadData = {29'd0, ien, 2'b00};
        R_STAT:  ReadData = {28'd0, ovf, err, done,
                             state != IDLE};
        R_MIN:   ReadData = mn;
        R_MAX:   ReadData = mx;
        R_SUM:   ReadData = sum;
        R_CNT:   ReadData = cnt;
        R_AVG:   ReadData = avg;
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_stats_mmio_peripheral.sv
// Bench for stats_mmio_peripheral: directed literal checks plus random
// traffic, every cycle compared with an arithmetic reference model.
module tb_stats_mmio_peripheral;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        hit;
`ifdef STATS_IRQ_EN
  logic        irq;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  stats_mmio_peripheral #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .Addr(Addr),
    .MemWrite(MemWrite),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .hit(hit)
`ifdef STATS_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  logic [31:0] m_min, m_max, m_sum, m_cnt, m_avg, p_avg;
  logic        m_done, m_err, m_ovf, m_ien, m_busy, p_err;
  int          m_left;
  bit          m_known = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit mhit(input logic [31:0] a);
    return (a >> 5) == (BASE >> 5);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (!mhit(a)) return 32'd0;
    case ((a - BASE) / 4)
      1: return {29'd0, m_ien, 2'b00};
      2: return {28'd0, m_ovf, m_err, m_done, m_busy};
      3: return m_min;
      4: return m_max;
      5: return m_sum;
      6: return m_cnt;
      7: return m_avg;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_model();
    m_min = 32'h7FFF_FFFF;
    m_max = 32'h8000_0000;
    m_sum = 0;
    m_cnt = 0;
    m_avg = 0;
    m_done = 0;
    m_err = 0;
    m_ovf = 0;
    m_busy = 0;
    m_left = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic rst);
    bit was_busy;
    longint t, s, c;
    if (rst) begin
      clear_model();
      m_ien = 0;
      m_known = 1;
      return;
    end
    was_busy = m_busy;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_avg = p_avg;
        m_err = p_err;
      end
    end
    if (we && mhit(a)) begin
      if ((a - BASE) / 4 == 0) begin
        if ($signed(wd) < $signed(m_min)) m_min = wd;
        if ($signed(wd) > $signed(m_max)) m_max = wd;
        t = longint'($signed(m_sum)) + longint'($signed(wd));
        if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf = 1;
        m_sum = 32'(t);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end else if ((a - BASE) / 4 == 1) begin
        m_ien = wd[2];
        if (wd[0]) begin
          clear_model();
        end else if (wd[1] && !was_busy) begin
          if (m_cnt == 0) begin
            p_avg = 0;
            p_err = 1;
            m_left = 1;
          end else begin
            s = longint'($signed(m_sum));
            c = longint'({32'd0, m_cnt});
            p_avg = 32'(s / c);
            p_err = 0;
            m_left = 33;
          end
          m_busy = 1;
          m_done = 0;
          m_err = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [31:0] a, input logic we,
                      input logic [31:0] wd, input logic rst,
                      input bit lit, input logic [31:0] lexp,
                      input string lname);
    @(negedge clk);
    Addr = a;
    MemWrite = we;
    WriteData = wd;
    reset = rst;
    #1;
    if (m_known) begin
      check("hit", {31'd0, hit}, {31'd0, mhit(a)});
      check("rdata", ReadData, mread(a));
`ifdef STATS_IRQ_EN
      check("irq", {31'd0, irq}, {31'd0, m_done & m_ien});
`endif
    end
    if (lit) check(lname, ReadData, lexp);
    @(posedge clk);
    model_edge(a, we, wd, rst);
    cyc++;
  endtask

  function automatic logic [31:0] ra(input int off);
    return BASE + 32'(off * 4);
  endfunction

  task automatic wr(input int off, input logic [31:0] d);
    step(ra(off), 1'b1, d, 1'b0, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input int off, input logic [31:0] e,
                    input string n);
    step(ra(off), 1'b0, 32'd0, 1'b0, 1'b1, e, n);
  endtask

  task automatic idle();
    step(ra(2), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "");
  endtask

  initial begin
    logic [31:0] a, d;
    int r;

    step(32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, "");
    rd(3, 32'h7FFF_FFFF, "rst_min");
    rd(4, 32'h8000_0000, "rst_max");
    rd(2, 32'd0, "rst_status");

    for (int i = 1; i <= 10; i++) wr(0, 32'(i));
    rd(3, 32'd1, "p1_min");
    rd(4, 32'd10, "p1_max");
    rd(5, 32'd55, "p1_sum");
    rd(6, 32'd10, "p1_cnt");
    wr(1, 32'd2);
    for (int i = 0; i < 33; i++) rd(2, 32'd1, "p1_busy");
    rd(7, 32'd5, "p1_avg");
    rd(2, 32'd2, "p1_done");

    wr(1, 32'd1);
    wr(0, 32'hFFFF_FFF9);
    wr(0, 32'd3);
    rd(5, 32'hFFFF_FFFC, "p2_sum");
    rd(3, 32'hFFFF_FFF9, "p2_min");
    rd(4, 32'd3, "p2_max");
    wr(1, 32'd2);
    for (int i = 0; i < 33; i++) idle();
    rd(7, 32'hFFFF_FFFE, "p2_avg");

    wr(1, 32'd1);
    wr(1, 32'd2);
    rd(2, 32'd1, "p3_busy");
    rd(2, 32'd6, "p3_err");
    rd(7, 32'd0, "p3_avg");

    wr(1, 32'd1);
    wr(0, 32'h7FFF_FFFF);
    wr(0, 32'd1);
    rd(5, 32'h8000_0000, "p4_sum");
    rd(2, 32'd8, "p4_ovf");
    wr(1, 32'd1);
    rd(3, 32'h7FFF_FFFF, "p4_clr_min");
    rd(5, 32'd0, "p4_clr_sum");
    rd(2, 32'd0, "p4_clr_status");

    wr(0, 32'd4);
    wr(0, 32'd6);
    wr(1, 32'd2);
    for (int i = 1; i <= 33; i++) begin
      if (i == 5) wr(0, 32'd100);
      else idle();
    end
    rd(7, 32'd5, "p5_avg");
    rd(6, 32'd3, "p5_cnt");
    rd(4, 32'd100, "p5_max");
    rd(5, 32'd110, "p5_sum");

    wr(1, 32'd2);
    for (int i = 1; i < 10; i++) idle();
    wr(1, 32'd1);
    rd(2, 32'd0, "p6_status");
    rd(7, 32'd0, "p6_avg");
    step(BASE + 32'd32, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, "p6_out_rd");
    check("p6_out_hit", {31'd0, hit}, 32'd0);

    wr(1, 32'd6);
    rd(1, 32'd4, "p7_ctrl");
    idle();
`ifdef STATS_IRQ_EN
    check("p7_irq_hi", {31'd0, irq}, 32'd1);
`endif
    wr(1, 32'd5);
    idle();
`ifdef STATS_IRQ_EN
    check("p7_irq_lo", {31'd0, irq}, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        step(32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, "");
      end else if (r < 40) begin
        case ($urandom_range(0, 3))
          0: d = 32'($urandom_range(0, 200)) - 32'd100;
          1: d = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
          2: d = 32'h8000_0000 + 32'($urandom_range(0, 3));
          default: d = $urandom;
        endcase
        wr(0, d);
      end else if (r < 50) begin
        d = $urandom & 32'hFFFF_FFF8;
        d[1] = $urandom_range(0, 1) == 1;
        d[2] = $urandom_range(0, 1) == 1;
        d[0] = $urandom_range(0, 12) == 0;
        wr(1, d);
      end else if (r < 55) begin
        a = ($urandom_range(0, 1) == 1) ? $urandom
                                         : ra($urandom_range(2, 7));
        step(a, 1'b1, $urandom, 1'b0, 1'b0, 32'd0, "");
      end else begin
        a = ($urandom_range(0, 9) == 0)
              ? $urandom
              : ra($urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        step(a, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stats_mmio_peripheral.md
Name: stats_mmio_peripheral

Overview:
- Memory-mapped statistics responder on the MIPS single-cycle CPU data bus.
- The CPU stores samples into it; the block keeps running signed min, max, sum and count.
- The CPU starts a multicycle average (sum/count) and polls for completion, then loads the results back.
- Sits beside data memory; the CPU's load mux selects its read data when `hit` is high.

Parameters:
- BASE_ADDR, 32'h0000_0100, word-aligned base of the 8-word register window.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- Addr, input, 32, byte address from the CPU (ALUResult).
- MemWrite, input, 1, store strobe; the write takes effect at the rising edge.
- WriteData, input, 32, store data.
- ReadData, output, 32, combinational load data for Addr.
- hit, output, 1, combinational; 1 when Addr[31:5] == BASE_ADDR[31:5].
- irq, output, 1, present only with STATS_IRQ_EN.

Behaviour:
- Addr[1:0] ignored. Offset = Addr[4:2].
- Register map:
  - 0 DATA: W pushes a sample; R returns 0.
  - 1 CTRL: W bit0 = CLEAR, bit1 = START, bit2 = IRQ_ENABLE (stored); R returns {29'b0, irq_enable, 2'b0}.
  - 2 STATUS: R {28'b0, ovf, err, done, busy}. Write ignored.
  - 3 MIN, 4 MAX, 5 SUM, 6 COUNT, 7 AVG: read-only.
- Reset and CLEAR state:
  - MIN = 32'h7FFF_FFFF, MAX = 32'h8000_0000.
  - SUM = 0, COUNT = 0, AVG = 0.
  - busy = done = err = ovf = 0; irq_enable = 0 (reset only, CLEAR keeps it).
  - ReadData = 0 and hit = 0 whenever Addr is outside the window.
- Sample push (store to DATA with hit):
  - MIN = smin(MIN, d), MAX = smax(MAX, d).
  - SUM = SUM + d, wrapping mod 2^32; ovf sets sticky on signed overflow.
  - COUNT saturates at 32'hFFFF_FFFF.
  - All updates land at the same edge; pushes are accepted while busy.
- Divider FSM states: IDLE, DIV, FIX.
  - IDLE -> DIV on a START write at edge E0:
    - snapshot SUM and COUNT;
    - load |SUM| and COUNT into a restoring divider;
    - busy = 1, done = 0, err = 0.
  - DIV: one quotient bit per edge, E1..E32.
  - FIX at E33:
    - AVG = quotient, negated if the SUM snapshot is negative (truncate toward zero);
    - busy = 0, done = 1; return to IDLE.
  - AVG is visible to loads after E33; total latency is 33 cycles after the START edge.
- COUNT snapshot == 0: at E1, AVG = 0, err = 1, done = 1, busy = 0; no division.
- START while busy: ignored.
- CLEAR while busy: aborts immediately at that edge, returns to IDLE, applies the full clear state.
- CLEAR and START in the same write: CLEAR wins and START is dropped.
- Pushes during DIV do not affect the quotient in progress (snapshot semantics).
- done clears on the next START or CLEAR only; reading STATUS does not clear it.
- reset mid-operation: returns to IDLE with reset values at that edge.

Optional Feature:
- Macro: STATS_IRQ_EN.
- When defined:
  - the `irq` port exists and is registered;
  - irq = done & irq_enable, updated at the same edge done changes;
  - irq is 0 at reset.
- When undefined:
  - no irq port, and no logic beyond the stored CTRL bit2;
  - CTRL bit2 is still writable and readable.

Test Plan:
- Reset, then push 1..10 at BASE+0, then START:
  - MIN = 1, MAX = 10, SUM = 55, COUNT = 10 immediately;
  - busy = 1 for cycles 1-32;
  - at cycle 33: AVG = 5, STATUS = 4'b0010.
- Push -7 and 3, then START:
  - SUM = 32'hFFFF_FFFC, MIN = -7, MAX = 3;
  - AVG = 32'hFFFF_FFFE (-2) after 33 cycles.
- START with COUNT = 0: one cycle later STATUS = 4'b0110 and AVG = 0.
- Push 0x7FFF_FFFF then 1:
  - SUM = 32'h8000_0000, ovf = 1;
  - CLEAR returns every register to its reset value.
- Push 4 and 6, START, push 100 at cycle 5:
  - AVG = 5 at cycle 33;
  - COUNT = 3, MAX = 100, SUM = 110 afterwards.
- START, then CLEAR at cycle 10:
  - busy = 0, done = 0 next cycle, AVG = 0;
  - Addr = BASE+32 gives hit = 0 and ReadData = 0.
- With STATS_IRQ_EN and CTRL = 3'b110: irq rises on the done edge and falls on the next CLEAR.
